// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the seven-segment scan controller
package seg_scan_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        OFF,
        BLANKING,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - mod-DIV slot counter with blanking-window and slot-end flags
module scan_prescaler #(
    parameter int DIV   = 125000,
    parameter int BLANK = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_clear,
    output logic [$clog2(DIV)-1:0] o_count,
    output logic                   o_slot_end,
    output logic                   o_in_blank
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] r_count;

    // Count 0..DIV-1 per scan slot; held at zero while cleared
    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_count <= '0;
        end else if (o_slot_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_slot_end = (r_count == CW'(DIV - 1));
    assign o_in_blank = (r_count < CW'(BLANK));

endmodule

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - multiplexed seven-segment digit scanner with frame-aligned double buffer
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 125000,
    parameter int BLANK      = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           lz_suppress,
    input  logic [NUM_DIGITS-1:0]          digit_mask,
    input  logic                           load_valid,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
    output logic                           load_ready,
    output logic [NUM_DIGITS-1:0]          anode_n,
    output logic [2:0]                     digit_sel,
    output logic [3:0]                     digit_code,
    output logic                           blank,
    output logic                           frame_start
);

    localparam int CW = $clog2(DIV);
    localparam int DW = NIBBLE_W * NUM_DIGITS;

    scan_state_t           r_state;
    logic [2:0]            r_idx;
    logic [DW-1:0]         r_pending;
    logic [DW-1:0]         r_active;
    logic                  r_pending_full;
    logic                  r_load_ready;
    logic [NUM_DIGITS-1:0] r_anode_n;
    logic [2:0]            r_digit_sel;
    logic [3:0]            r_digit_code;
    logic                  r_blank;
    logic                  r_frame_start;

    logic [CW-1:0]         w_count;
    logic                  w_slot_end;
    logic                  w_in_blank;
    logic                  w_clear;
    logic                  w_last_idx;
    logic                  w_commit;
    logic                  w_capture;
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic [3:0]            w_code;
    logic                  w_dark;
    logic                  w_lit;

    // The prescaler only runs while a scan is in progress
    assign w_clear = !enable || (r_state == OFF);

    scan_prescaler #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_prescaler (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_clear),
        .o_count    (w_count),
        .o_slot_end (w_slot_end),
        .o_in_blank (w_in_blank)
    );

    assign w_last_idx = (r_idx == 3'(NUM_DIGITS - 1));
    // Commit only between frames: end of the last slot, or whenever idle
    assign w_commit   = r_pending_full &&
                        ((r_state == OFF) || (enable && w_slot_end && w_last_idx));
    assign w_capture  = load_valid && !r_pending_full;

    // Scan sequencing: slot phase follows the prescaler, idx advances per slot
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            r_state <= OFF;
            r_idx   <= '0;
        end else begin
            case (r_state)
                OFF: begin
                    r_state <= BLANKING;
                    r_idx   <= '0;
                end
                BLANKING: begin
                    if (w_count == CW'(BLANK - 1)) begin
                        r_state <= SHOW;
                    end
                end
                SHOW: begin
                    if (w_slot_end) begin
                        r_state <= BLANKING;
                        r_idx   <= w_last_idx ? 3'd0 : r_idx + 3'd1;
                    end
                end
                default: begin
                    r_state <= OFF;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Shadow register accepts one word; it moves to active at a frame boundary
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending      <= '0;
            r_active       <= '0;
            r_pending_full <= 1'b0;
            r_load_ready   <= 1'b1;
        end else if (w_commit) begin
            r_active       <= r_pending;
            r_pending_full <= 1'b0;
            r_load_ready   <= 1'b1;
        end else if (w_capture) begin
            r_pending      <= load_data;
            r_pending_full <= 1'b1;
            r_load_ready   <= 1'b0;
        end
    end

    // Leading-zero detection and nibble select for the digit under scan
    always_comb begin
        logic w_all_zero;
        w_all_zero   = 1'b1;
        w_upper_zero = '0;
        w_code       = '0;
        w_dark       = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_all_zero      = w_all_zero && (r_active[i*NIBBLE_W +: NIBBLE_W] == '0);
            w_upper_zero[i] = w_all_zero;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
                w_code = r_active[i*NIBBLE_W +: NIBBLE_W];
                w_dark = !digit_mask[i] || (lz_suppress && (i != 0) && w_upper_zero[i]);
            end
        end
    end

    assign w_lit = (r_state == SHOW) && !w_in_blank && !w_dark;

    // Output registers, one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_anode_n     <= '1;
            r_digit_sel   <= '0;
            r_digit_code  <= '0;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_digit_sel   <= r_idx;
            r_digit_code  <= w_code;
            r_anode_n     <= w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
            r_blank       <= !w_lit;
            r_frame_start <= (r_state == BLANKING) && (r_idx == 3'd0) && (w_count == '0);
        end
    end

    assign load_ready  = r_load_ready;
    assign anode_n     = r_anode_n;
    assign digit_sel   = r_digit_sel;
    assign digit_code  = r_digit_code;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - self-checking bench for seg_scan_controller
module tb_seg_scan_controller;

    localparam int N = 4;
    localparam int D = 8;
    localparam int B = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         lz_suppress = 1'b0;
    logic [N-1:0] digit_mask = 4'hF;
    logic         load_valid = 1'b0;
    logic [15:0]  load_data = 16'h0;
    logic         load_ready;
    logic [N-1:0] anode_n;
    logic [2:0]   digit_sel;
    logic [3:0]   digit_code;
    logic         blank;
    logic         frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] sb[$];
    logic [23:0] obs[N];
    logic        obs_next_fs;
    int          obs_fs_extra;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .NUM_DIGITS (N),
        .DIV        (D),
        .BLANK      (B)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .lz_suppress (lz_suppress),
        .digit_mask  (digit_mask),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .anode_n     (anode_n),
        .digit_sel   (digit_sel),
        .digit_code  (digit_code),
        .blank       (blank),
        .frame_start (frame_start)
    );

    // {anode at slot end, code at slot end, lit cycles, offset of first lit cycle}
    function automatic logic [23:0] slot_exp(input int s, input bit lit, input logic [3:0] nib);
        logic [3:0] an;
        an = 4'hF;
        if (lit) an[s[1:0]] = 1'b0;
        return {an, nib, lit ? 8'(D - B) : 8'd0, lit ? 8'(B) : 8'(D)};
    endfunction

    // Waits (bounded) for frame_start at a falling edge, then records one frame slot by slot
    task automatic collect_frame(output bit found);
        int lit;
        int first;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) return;
        obs_fs_extra = 0;
        for (int s = 0; s < N; s++) begin
            lit   = 0;
            first = D;
            for (int c = 0; c < D; c++) begin
                if ((s != 0 || c != 0) && frame_start === 1'b1) obs_fs_extra++;
                if (anode_n !== 4'hF) begin
                    if (lit == 0) first = c;
                    lit++;
                end
                if (c == D - 1) obs[s] = {anode_n, digit_code, 8'(lit), 8'(first)};
                @(negedge clk);
            end
        end
        obs_next_fs = frame_start;
    endtask

    // Presents one word and holds it until the handshake completes; returns at the next falling edge
    task automatic load_word(input logic [15:0] v, output bit ok);
        ok         = 1'b0;
        load_valid = 1'b1;
        load_data  = v;
        for (int k = 0; k < 100; k++) begin
            if (load_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic test_reset;
        enable  = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({anode_n, blank, load_ready, frame_start} !== {4'hF, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_flags: got an=%b bl=%b rdy=%b fs=%b want an=1111 bl=1 rdy=1 fs=0",
                     anode_n, blank, load_ready, frame_start);
        end
        n_cmp++;
        if ({digit_sel, digit_code} !== {3'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_sel_code: got sel=%0d code=%h want sel=0 code=0", digit_sel, digit_code);
        end
        enable  = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({anode_n, blank} !== {4'hF, 1'b1}) begin
            n_bad++;
            $display("FAIL off_dark: got an=%b bl=%b want an=1111 bl=1", anode_n, blank);
        end
    endtask

    task automatic test_basic_scan;
        bit ok;
        bit found;
        int lat;
        load_word(16'h1234, ok);
        n_cmp++;
        if (!ok || load_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_capture: got ok=%b rdy=%b want ok=1 rdy=0", ok, load_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL off_commit_ready: got rdy=%b want 1", load_ready);
        end
        digit_mask  = 4'hF;
        lz_suppress = 1'b0;
        enable      = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (anode_n !== 4'hF) break;
        end
        n_cmp++;
        if (lat != B + 1 || anode_n !== 4'b1110) begin
            n_bad++;
            $display("FAIL first_anode: got %0d cycles an=%b want %0d cycles an=1110", lat, anode_n, B + 1);
        end
        sb.push_back(slot_exp(0, 1, 4'h4));
        sb.push_back(slot_exp(1, 1, 4'h3));
        sb.push_back(slot_exp(2, 1, 4'h2));
        sb.push_back(slot_exp(3, 1, 4'h1));
        collect_frame(found);
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL basic_frame: got no frame_start want one within 200 cycles");
            sb.delete();
        end else begin
            for (int s = 0; s < N; s++) begin
                n_cmp++;
                if (obs[s] !== sb[0]) begin
                    n_bad++;
                    $display("FAIL basic_slot%0d: got %h want %h", s, obs[s], sb[0]);
                end
                void'(sb.pop_front());
            end
            n_cmp++;
            if (obs_next_fs !== 1'b1 || obs_fs_extra != 0) begin
                n_bad++;
                $display("FAIL basic_period: got next_fs=%b extra=%0d want next_fs=1 extra=0", obs_next_fs, obs_fs_extra);
            end
        end
    endtask

    task automatic test_leading_zeros;
        bit ok;
        bit found;
        enable = 1'b0;
        @(negedge clk);
        load_word(16'h0070, ok);
        @(negedge clk);
        lz_suppress = 1'b1;
        enable      = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                lz_suppress = 1'b0;
                @(negedge clk);
            end
            sb.push_back(slot_exp(0, 1, 4'h0));
            sb.push_back(slot_exp(1, 1, 4'h7));
            sb.push_back(slot_exp(2, pass == 1, 4'h0));
            sb.push_back(slot_exp(3, pass == 1, 4'h0));
            collect_frame(found);
            n_cmp++;
            if (!ok || !found) begin
                n_bad++;
                $display("FAIL lz_frame%0d: got load_ok=%b found=%b want 1 1", pass, ok, found);
                sb.delete();
            end else begin
                for (int s = 0; s < N; s++) begin
                    n_cmp++;
                    if (obs[s] !== sb[0]) begin
                        n_bad++;
                        $display("FAIL lz%0d_slot%0d: got %h want %h", pass, s, obs[s], sb[0]);
                    end
                    void'(sb.pop_front());
                end
            end
        end
        lz_suppress = 1'b0;
    endtask

    task automatic test_double_buffer;
        bit ok;
        bit found;
        int hold_bad;
        bit seen_ready;
        logic [3:0] exp_code;
        logic [15:0] words [3];
        words[0] = 16'h1234;
        words[1] = 16'h5678;
        words[2] = 16'h9ABC;
        enable = 1'b0;
        @(negedge clk);
        load_word(16'h1234, ok);
        @(negedge clk);
        enable = 1'b1;
        collect_frame(found);
        repeat (10) @(negedge clk);
        load_word(16'h5678, ok);
        n_cmp++;
        if (!ok || load_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL db_ready_low: got ok=%b rdy=%b want ok=1 rdy=0", ok, load_ready);
        end
        load_valid = 1'b1;
        load_data  = 16'h9ABC;
        hold_bad   = 0;
        seen_ready = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (load_ready === 1'b1) begin
                seen_ready = 1'b1;
                break;
            end
            if (frame_start === 1'b1) hold_bad++;
            if (anode_n !== 4'hF) begin
                case (anode_n)
                    4'b1110: exp_code = 4'h4;
                    4'b1101: exp_code = 4'h3;
                    4'b1011: exp_code = 4'h2;
                    4'b0111: exp_code = 4'h1;
                    default: exp_code = 4'hF;
                endcase
                if (digit_code !== exp_code || exp_code == 4'hF) hold_bad++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen_ready || hold_bad != 0) begin
            n_bad++;
            $display("FAIL db_old_hold: got ready_seen=%b bad_cycles=%0d want ready_seen=1 bad_cycles=0", seen_ready, hold_bad);
        end
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        n_cmp++;
        if ({load_ready, frame_start} !== 2'b01) begin
            n_bad++;
            $display("FAIL db_second_capture: got rdy=%b fs=%b want rdy=0 fs=1", load_ready, frame_start);
        end
        for (int f = 1; f < 3; f++) begin
            for (int s = 0; s < N; s++) sb.push_back(slot_exp(s, 1, words[f][s*4 +: 4]));
            collect_frame(found);
            n_cmp++;
            if (!found) begin
                n_bad++;
                $display("FAIL db_frame%0d: got no frame_start want one within 200 cycles", f);
                sb.delete();
            end else begin
                for (int s = 0; s < N; s++) begin
                    n_cmp++;
                    if (obs[s] !== sb[0]) begin
                        n_bad++;
                        $display("FAIL db%0d_slot%0d: got %h want %h", f, s, obs[s], sb[0]);
                    end
                    void'(sb.pop_front());
                end
            end
        end
    endtask

    task automatic test_enable_drop;
        bit found;
        int cnt;
        repeat (2 * D + B + 2) @(negedge clk);
        n_cmp++;
        if ({anode_n, digit_code} !== {4'b1011, 4'hA}) begin
            n_bad++;
            $display("FAIL drop_pre: got an=%b code=%h want an=1011 code=a", anode_n, digit_code);
        end
        enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({anode_n, blank, digit_sel} !== {4'hF, 1'b1, 3'd0}) begin
            n_bad++;
            $display("FAIL drop_dark: got an=%b bl=%b sel=%0d want an=1111 bl=1 sel=0", anode_n, blank, digit_sel);
        end
        enable = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            if (frame_start === 1'b1) break;
        end
        n_cmp++;
        if (cnt != 1 || frame_start !== 1'b1) begin
            n_bad++;
            $display("FAIL reenable_fs: got %0d cycles fs=%b want 1 cycle fs=1", cnt, frame_start);
        end
        sb.push_back(slot_exp(0, 1, 4'hC));
        sb.push_back(slot_exp(1, 1, 4'hB));
        sb.push_back(slot_exp(2, 1, 4'hA));
        sb.push_back(slot_exp(3, 1, 4'h9));
        collect_frame(found);
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL restart_frame: got no frame_start want one within 200 cycles");
            sb.delete();
        end else begin
            for (int s = 0; s < N; s++) begin
                n_cmp++;
                if (obs[s] !== sb[0]) begin
                    n_bad++;
                    $display("FAIL restart_slot%0d: got %h want %h", s, obs[s], sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic test_mask_reset;
        bit ok;
        bit found;
        digit_mask = 4'b1010;
        @(negedge clk);
        sb.push_back(slot_exp(0, 0, 4'hC));
        sb.push_back(slot_exp(1, 1, 4'hB));
        sb.push_back(slot_exp(2, 0, 4'hA));
        sb.push_back(slot_exp(3, 1, 4'h9));
        collect_frame(found);
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL mask_frame: got no frame_start want one within 200 cycles");
            sb.delete();
        end else begin
            for (int s = 0; s < N; s++) begin
                n_cmp++;
                if (obs[s] !== sb[0]) begin
                    n_bad++;
                    $display("FAIL mask_slot%0d: got %h want %h", s, obs[s], sb[0]);
                end
                void'(sb.pop_front());
            end
        end
        digit_mask = 4'hF;
        repeat (5) @(negedge clk);
        load_word(16'h4321, ok);
        n_cmp++;
        if (!ok || load_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mr_pending: got ok=%b rdy=%b want ok=1 rdy=0", ok, load_ready);
        end
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_cmp++;
        if ({load_ready, anode_n, frame_start} !== {1'b1, 4'hF, 1'b0}) begin
            n_bad++;
            $display("FAIL mr_reset: got rdy=%b an=%b fs=%b want rdy=1 an=1111 fs=0", load_ready, anode_n, frame_start);
        end
        for (int s = 0; s < N; s++) sb.push_back(slot_exp(s, 1, 4'h0));
        collect_frame(found);
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL mr_frame: got no frame_start want one within 200 cycles");
            sb.delete();
        end else begin
            for (int s = 0; s < N; s++) begin
                n_cmp++;
                if (obs[s] !== sb[0]) begin
                    n_bad++;
                    $display("FAIL mr_slot%0d: got %h want %h", s, obs[s], sb[0]);
                end
                void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic_scan;
        test_leading_zeros;
        test_double_buffer;
        test_enable_drop;
        test_mask_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
